// File: rtl/mpu_ctrl_pkg.sv
// Shared types and constants for the MPU6050 sample controller.
// Byte order of one accel frame as it arrives from the I2C burst read.
package mpu_ctrl_pkg;

   typedef enum logic [2:0] {
      StOff,
      StHold,
      StPwrup,
      StInit,
      StInitWait,
      StStart,
      StStream,
      StFault
   } ctrl_state_t;

   localparam int unsigned FRAME_BYTES_DEF = 6;

   localparam int unsigned IDX_XH = 0;
   localparam int unsigned IDX_XL = 1;
   localparam int unsigned IDX_YH = 2;
   localparam int unsigned IDX_YL = 3;
   localparam int unsigned IDX_ZH = 4;
   localparam int unsigned IDX_ZL = 5;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mpu_frame_asm.sv
// Collects captured bytes into XH..ZL order and publishes a full sample
// with a one-cycle strobe the cycle after the last byte is captured.
module mpu_frame_asm
   import mpu_ctrl_pkg::*;
#(
   parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_byte_stb,
   input  logic [7:0]  i_byte,
   input  logic        i_clr,
   output logic [15:0] o_accel_x,
   output logic [15:0] o_accel_y,
   output logic [15:0] o_accel_z,
   output logic        o_sample_valid
);

   localparam int unsigned IDX_W = $clog2(FRAME_BYTES);

   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_buf   [FRAME_BYTES];
   logic [7:0]       w_frame [FRAME_BYTES];
   logic [15:0]      r_accel_x, r_accel_y, r_accel_z;
   logic             r_sample_valid;
   logic             w_last;

   assign w_last = i_byte_stb && (r_idx == IDX_W'(FRAME_BYTES - 1));

   // The final byte is still on i_byte when the frame completes.
   always_comb begin
      for (int k = 0; k < FRAME_BYTES; k++) begin
         w_frame[k] = (IDX_W'(k) == r_idx) ? i_byte : r_buf[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx          <= '0;
         r_sample_valid <= 1'b0;
         r_accel_x      <= '0;
         r_accel_y      <= '0;
         r_accel_z      <= '0;
         for (int k = 0; k < FRAME_BYTES; k++) r_buf[k] <= '0;
      end else begin
         r_sample_valid <= 1'b0;
         if (i_clr) begin
            r_idx <= '0;
         end else if (i_byte_stb) begin
            r_buf[r_idx] <= i_byte;
            if (w_last) begin
               r_idx          <= '0;
               r_accel_x      <= {w_frame[IDX_XH], w_frame[IDX_XL]};
               r_accel_y      <= {w_frame[IDX_YH], w_frame[IDX_YL]};
               r_accel_z      <= {w_frame[IDX_ZH], w_frame[IDX_ZL]};
               r_sample_valid <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign o_accel_x      = r_accel_x;
   assign o_accel_y      = r_accel_y;
   assign o_accel_z      = r_accel_z;
   assign o_sample_valid = r_sample_valid;

endmodule

// File: rtl/mpu_sample_ctrl.sv
// Sequences the I2C master for the MPU6050: reset, power-up wait, init,
// continuous burst reads, and fault recovery by resetting the master.
module mpu_sample_ctrl
   import mpu_ctrl_pkg::*;
#(
   parameter int unsigned CLK_MAIN     = 50000000,
   parameter int unsigned PWRUP_CYCLES = 5000000,
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned INIT_TIMEOUT = 250000,
   parameter int unsigned BYTE_TIMEOUT = 100000,
   parameter int unsigned GAP_CYCLES   = 2000,
   parameter int unsigned RETRY_WAIT   = 500000,
   parameter int unsigned FRAME_BYTES  = FRAME_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_enable,
   output logic        o_iic_rst_n,
   output logic        o_iic_init,
   output logic        o_iic_transfer,
   input  logic        i_iic_busy,
   input  logic        i_iic_data_valid,
   input  logic [7:0]  i_iic_data,
   output logic [15:0] o_accel_x,
   output logic [15:0] o_accel_y,
   output logic [15:0] o_accel_z,
   output logic        o_sample_valid,
   output logic        o_running,
   output logic        o_fault,
   output logic [7:0]  o_err_cnt
);

   // Byte order and packing are fixed for the six-byte accel burst.
   if (FRAME_BYTES != 6 || CLK_MAIN == 0) begin : g_bad_cfg
      $error("mpu_sample_ctrl: unsupported configuration");
   end

   ctrl_state_t r_state, w_state_nxt;
   logic [31:0] r_cnt, w_cnt_nxt;
   logic [31:0] r_gap_cnt, w_gap_nxt;
   logic        r_busy_seen;
   logic        r_dv_prev;
   logic [7:0]  r_err_cnt;
   logic        w_stream, w_cap, w_gap_hit, w_asm_clr, w_state_chg;

   assign w_stream    = (r_state == StStream);
   assign w_cap       = w_stream && i_iic_data_valid && !r_dv_prev;
   assign w_gap_hit   = w_stream && !w_cap && (r_gap_cnt == GAP_CYCLES - 1);
   // Anything outside STREAM discards a partial frame.
   assign w_asm_clr   = !w_stream || w_gap_hit;
   assign w_state_chg = (w_state_nxt != r_state);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StOff:      if (i_enable) w_state_nxt = StHold;
         StHold:     if (r_cnt == RST_CYCLES - 1) w_state_nxt = StPwrup;
         StPwrup:    if (r_cnt == PWRUP_CYCLES - 1) w_state_nxt = StInit;
         StInit:     w_state_nxt = StInitWait;
         StInitWait: begin
            if (r_busy_seen && !i_iic_busy)         w_state_nxt = StStart;
            else if (r_cnt == INIT_TIMEOUT - 1)    w_state_nxt = StFault;
         end
         StStart:    w_state_nxt = StStream;
         StStream:   if (!w_cap && r_cnt == BYTE_TIMEOUT - 1) w_state_nxt = StFault;
         StFault:    if (r_cnt == RETRY_WAIT - 1) w_state_nxt = StHold;
         default:    w_state_nxt = StOff;
      endcase
      if (!i_enable) w_state_nxt = StOff;
   end

   always_comb begin
      w_cnt_nxt = r_cnt + 32'd1;
      if (w_state_chg || r_state == StOff || w_cap) w_cnt_nxt = '0;
      w_gap_nxt = r_gap_cnt + 32'd1;
      if (!w_stream || w_cap || w_gap_hit) w_gap_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= StOff;
         r_cnt       <= '0;
         r_gap_cnt   <= '0;
         r_busy_seen <= 1'b0;
         r_dv_prev   <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_dv_prev <= i_iic_data_valid;
         if (w_state_chg) begin
            r_busy_seen <= 1'b0;
         end else if (r_state == StInitWait && i_iic_busy) begin
            r_busy_seen <= 1'b1;
         end
         if (w_state_nxt == StFault && r_state != StFault) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
         end
      end
   end

   assign o_iic_rst_n    = r_state inside {StPwrup, StInit, StInitWait, StStart, StStream};
   assign o_iic_init     = (r_state == StInit);
   assign o_iic_transfer = (r_state == StStart);
   assign o_running      = w_stream;
   assign o_fault        = (r_state == StFault);
   assign o_err_cnt      = r_err_cnt;

   mpu_frame_asm #(
      .FRAME_BYTES (FRAME_BYTES)
   ) u_frame_asm (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_byte_stb     (w_cap),
      .i_byte         (i_iic_data),
      .i_clr          (w_asm_clr),
      .o_accel_x      (o_accel_x),
      .o_accel_y      (o_accel_y),
      .o_accel_z      (o_accel_z),
      .o_sample_valid (o_sample_valid)
   );

endmodule
